// File: rtl/period_meter_if.sv
// Request/result bundle between a controller and the period meter.
// The meter takes the slave side; the controller issuing start takes the master side.
interface period_meter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;

  modport master (
    output start,
    input  busy, done, timeout, period, high_time
  );

  modport slave (
    input  start,
    output busy, done, timeout, period, high_time
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a watchdog that posts a timeout when no full period arrives in time.
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sig_in,
  period_meter_if.slave bus
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  state_e           state_q;
  logic             s0_q, s1_q, s2_q;
  logic [WIDTH-1:0] cnt_q, hi_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             busy_q, done_q, timeout_q;
  logic [WIDTH-1:0] period_q, high_q;
  logic             rise_s, wd_last_s;

  // Edge detect on the synchronised input and a watchdog step that saturates at its limit.
  always_comb begin
    rise_s    = s1_q & ~s2_q;
    wd_last_s = (wd_q == WD_LAST);
    if (wd_last_s) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Synchroniser, measurement FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      s0_q   <= sig_in;
      s1_q   <= s0_q;
      s2_q   <= s1_q;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_ARM;
            wd_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          wd_q <= wd_d;
          if (rise_s) begin
            state_q <= ST_MEAS;
            cnt_q   <= WIDTH'(1);
            hi_q    <= WIDTH'(1);
          end else if (wd_last_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            period_q  <= '0;
            high_q    <= '0;
          end
        end
        // A rise landing on the watchdog's last cycle still yields a valid result.
        ST_MEAS: begin
          if (rise_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
            period_q  <= cnt_q;
            high_q    <= hi_q;
          end else if (wd_last_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            period_q  <= '0;
            high_q    <= '0;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
            hi_q  <= hi_q + WIDTH'(s1_q);
            wd_q  <= wd_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.period    = period_q;
  assign bus.high_time = high_q;

endmodule
